pm_upper_limit: RTL

PM_UPPER_LIMIT -- requirements
Module: pm_upper_limit

---
 rtl/pm_upper_limit.sv | 103 ++++++++++
 1 files changed

// File: rtl/pm_upper_limit.sv
// Upper power limiter: clamps an IEEE-754 single operand to PMAX over a fixed
// three-stage pipeline and counts how many results were limited.
module pm_upper_limit #(
    parameter logic [31:0] PMAX = 32'h3F800000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rst_user,
    input  logic        sta,
    input  logic [31:0] x,
    output logic [31:0] y,
    output logic        done_sig,
    output logic        sat_hi,
    output logic [15:0] sat_cnt
);

    localparam logic [7:0]  PMAX_EXP = PMAX[30:23];
    localparam logic [22:0] PMAX_MAN = PMAX[22:0];

    // NaN of either sign is limited; otherwise only positive operands whose
    // magnitude (exponent first, then mantissa) exceeds PMAX are limited.
    function automatic logic exceeds_pmax(input logic [31:0] v);
        logic [7:0]  exp_v;
        logic [22:0] man_v;
        logic        is_nan;
        logic        mag_gt;
        exp_v  = v[30:23];
        man_v  = v[22:0];
        is_nan = (exp_v == 8'hFF) && (man_v != 23'h000000);
        if (exp_v > PMAX_EXP) begin
            mag_gt = 1'b1;
        end else if (exp_v == PMAX_EXP) begin
            mag_gt = (man_v > PMAX_MAN);
        end else begin
            mag_gt = 1'b0;
        end
        return is_nan || (!v[31] && mag_gt);
    endfunction

    logic        s1_vld_r;
    logic [31:0] s1_x_r;
    logic        s1_lim_s;
    logic        s2_vld_r;
    logic [31:0] s2_x_r;
    logic        s2_lim_r;

    // Magnitude compare of the operand held in stage 1.
    always_comb begin
        s1_lim_s = exceeds_pmax(s1_x_r);
    end

    // Stage 1 and stage 2: operand capture, then compare outcome capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld_r <= 1'b0;
            s1_x_r   <= 32'h00000000;
            s2_vld_r <= 1'b0;
            s2_x_r   <= 32'h00000000;
            s2_lim_r <= 1'b0;
        end else if (rst_user) begin
            s1_vld_r <= 1'b0;
            s2_vld_r <= 1'b0;
        end else begin
            s1_vld_r <= sta;
            s1_x_r   <= x;
            s2_vld_r <= s1_vld_r;
            s2_x_r   <= s1_x_r;
            s2_lim_r <= s1_lim_s;
        end
    end

    // Stage 3: result, flag and strobe; y and sat_hi hold between results.
    always_ff @(posedge clk) begin
        if (rst) begin
            y        <= 32'h00000000;
            sat_hi   <= 1'b0;
            done_sig <= 1'b0;
        end else if (rst_user) begin
            done_sig <= 1'b0;
        end else begin
            done_sig <= s2_vld_r;
            if (s2_vld_r) begin
                y      <= s2_lim_r ? PMAX : s2_x_r;
                sat_hi <= s2_lim_r;
            end else begin
                y      <= y;
                sat_hi <= sat_hi;
            end
        end
    end

    // Saturating count of limited results, updated with the completing result.
    always_ff @(posedge clk) begin
        if (rst || rst_user) begin
            sat_cnt <= 16'h0000;
        end else if (s2_vld_r && s2_lim_r && (sat_cnt != 16'hFFFF)) begin
            sat_cnt <= sat_cnt + 16'h0001;
        end else begin
            sat_cnt <= sat_cnt;
        end
    end

endmodule
